// File: rtl/inv_sbox_engine.sv
// Sequential AES InvSubBytes engine: accepts one 128-bit state, substitutes
// LANES bytes per cycle through the inverse S-box, then hands the result back.
module inv_sbox_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Entry 0 sits in the top byte, so entry x lives at bit offset (255-x)*8.
  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [127:0]  wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  sub;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_TBL[{~x, 3'b000} +: 8];
  endfunction

  // Current byte group of wr replaced by its inverse S-box image.
  always_comb begin
    sub = wr_q;
    for (int k = 0; k < LANES; k++) begin
      sub[(int'(cnt_q) * LANES + k) * 8 +: 8] =
        inv_sbox(wr_q[(int'(cnt_q) * LANES + k) * 8 +: 8]);
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_d    = in_data;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        wr_d = sub;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // Consuming a result and accepting the next state share one edge.
        if (out_ready) begin
          if (in_valid) begin
            wr_d    = in_data;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign out_data  = wr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inv_sbox_engine.sv
// Directed bench for inv_sbox_engine: main LANES=4 instance plus LANES=1/2/16
// instances for the latency sweep.
module tb_inv_sbox_engine;

  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] VEC1 = {96'h0, 32'h52167c63};
  localparam logic [127:0] EXP1 = {{12{8'h52}}, 32'h48ff0100};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready;
  logic [127:0] in_data;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  logic         sw_valid;
  logic [127:0] sw_data;
  logic         rdy1, rdy2, rdy16, ov1, ov2, ov16, bz1, bz2, bz16;
  logic [127:0] od1, od2, od16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inv_sbox_engine #(.LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy));

  inv_sbox_engine #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy1),
    .in_data(sw_data), .out_valid(ov1), .out_ready(1'b1),
    .out_data(od1), .busy(bz1));

  inv_sbox_engine #(.LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy2),
    .in_data(sw_data), .out_valid(ov2), .out_ready(1'b1),
    .out_data(od2), .busy(bz2));

  inv_sbox_engine #(.LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy16),
    .in_data(sw_data), .out_valid(ov16), .out_ready(1'b1),
    .out_data(od16), .busy(bz16));

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return FWD_TBL[{~x, 3'b000} +: 8];
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one state, wait for acceptance and the result; lat counts edges
  // from the accepting edge inclusive until out_valid is seen.
  task automatic applyStimulus(input logic [127:0] data, output logic [127:0] res,
                               output int lat, output bit runOk);
    int guard = 0;
    runOk    = 1'b1;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready || !busy) runOk = 1'b0;
      step();
      lat++;
    end
    res = out_data;
  endtask

  initial begin
    logic [127:0] res, exp, d1, d2, data;
    int lat, c2, c, l1, l2, l16;
    bit runOk;
    logic [127:0] r1, r2, r16;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    sw_valid  = 1'b0;
    sw_data   = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_busy",      128'(busy),      128'(0));
    checkOutput("rst_out_data",  out_data,        128'(0));
    checkOutput("rst_in_ready",  128'(in_ready),  128'(1));
    @(negedge clk) rst_n = 1'b1;
    step();

    // Scenario 1: basic vector
    applyStimulus(VEC1, res, lat, runOk);
    checkOutput("s1_latency", 128'(lat), 128'(5));
    checkOutput("s1_data", res, EXP1);
    checkOutput("s1_run_flags", 128'(runOk), 128'(1));
    step();
    checkOutput("s1_consumed_valid", 128'(out_valid), 128'(0));
    checkOutput("s1_idle_ready", 128'(in_ready), 128'(1));

    // Scenario 2: round trip through the forward table
    for (int s = 0; s < 16; s++) begin
      for (int b = 0; b < 16; b++) begin
        data[b*8 +: 8] = sbox(8'(s * 16 + b));
        exp[b*8 +: 8]  = 8'(s * 16 + b);
      end
      applyStimulus(data, res, lat, runOk);
      checkOutput($sformatf("s2_roundtrip_%0d", s), res, exp);
      step();
    end

    // Scenario 3: backpressure
    out_ready = 1'b0;
    applyStimulus(VEC1, res, lat, runOk);
    checkOutput("s3_latency", 128'(lat), 128'(5));
    in_valid = 1'b1;
    in_data  = {16{8'h63}};
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput($sformatf("s3_hold_valid_%0d", i), 128'(out_valid), 128'(1));
      checkOutput($sformatf("s3_hold_data_%0d", i), out_data, EXP1);
      checkOutput($sformatf("s3_hold_ready_%0d", i), 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    checkOutput("s3_release_valid", 128'(out_valid), 128'(0));
    checkOutput("s3_release_busy", 128'(busy), 128'(0));
    checkOutput("s3_release_ready", 128'(in_ready), 128'(1));

    // Scenario 4: back-to-back acceptance
    in_data  = {16{8'h52}};
    in_valid = 1'b1;
    step();
    in_data = VEC1;
    c = 1;
    while (!out_valid && c < 40) begin
      step();
      c++;
    end
    d1 = out_data;
    checkOutput("s4_first_latency", 128'(c), 128'(5));
    checkOutput("s4_ready_in_done", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    checkOutput("s4_second_running", 128'({busy, out_valid}), 128'(2'b10));
    c2 = 1;
    while (!out_valid && c2 < 40) begin
      step();
      c2++;
    end
    d2 = out_data;
    checkOutput("s4_spacing", 128'(c2), 128'(5));
    checkOutput("s4_first_data", d1, {16{8'h48}});
    checkOutput("s4_second_data", d2, EXP1);
    step();

    // Scenario 5: reset in the middle of RUN
    in_data  = VEC1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checkOutput("s5_busy_before", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_valid", 128'(out_valid), 128'(0));
    checkOutput("s5_rst_busy", 128'(busy), 128'(0));
    checkOutput("s5_rst_data", out_data, 128'(0));
    @(negedge clk) rst_n = 1'b1;
    step();
    applyStimulus({16{8'h63}}, res, lat, runOk);
    checkOutput("s5_latency", 128'(lat), 128'(5));
    checkOutput("s5_data", res, 128'(0));
    step();

    // Scenario 6: LANES sweep
    checkOutput("s6_ready", 128'({rdy1, rdy2, rdy16}), 128'(3'b111));
    sw_data  = VEC1;
    sw_valid = 1'b1;
    l1 = 0; l2 = 0; l16 = 0;
    r1 = '0; r2 = '0; r16 = '0;
    step();
    sw_valid = 1'b0;
    sw_data  = '0;
    for (int k = 1; k <= 30; k++) begin
      if (ov1 && l1 == 0) begin l1 = k; r1 = od1; end
      if (ov2 && l2 == 0) begin l2 = k; r2 = od2; end
      if (ov16 && l16 == 0) begin l16 = k; r16 = od16; end
      step();
    end
    checkOutput("s6_lat_lanes1", 128'(l1), 128'(17));
    checkOutput("s6_lat_lanes2", 128'(l2), 128'(9));
    checkOutput("s6_lat_lanes16", 128'(l16), 128'(2));
    checkOutput("s6_data_lanes1", r1, EXP1);
    checkOutput("s6_data_lanes2", r2, EXP1);
    checkOutput("s6_data_lanes16", r16, EXP1);
    checkOutput("s6_idle_after", 128'({bz1, bz2, bz16}), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
